// File: rtl/mem_stage_pipe_if.sv
// Execute-to-memory-stage bundle: request side (in_*) and registered result side (out_*).
interface mem_stage_pipe_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [0:DATA_W-1] alu_result;
  logic [0:DATA_W-1] wr_data;
  logic              zero;
  logic              branch;
  logic              mem_write;
  logic              mem_read;
  logic [1:0]        size;
  logic [0:DATA_W-1] read_data;
  logic              pc_src;
  logic              err;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_valid, alu_result, wr_data, zero, branch, mem_write, mem_read, size, out_ready,
    input  in_ready, read_data, pc_src, err, out_valid
  );

  modport slave (
    input  in_valid, alu_result, wr_data, zero, branch, mem_write, mem_read, size, out_ready,
    output in_ready, read_data, pc_src, err, out_valid
  );
endinterface

// File: rtl/mem_stage_pipe.sv
// Memory stage: load/store plus branch resolve, WAIT_STATES+1 cycles accept-to-valid, one txn in flight,
// results held until out_ready. Sub-word (byte/half) accesses enabled by `define MEM_STAGE_SUBWORD_EN.
module mem_stage_pipe #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input logic             clk_i,
  input logic             rst_i,
  mem_stage_pipe_if.slave bus
);

  localparam int                BYTES   = DATA_W / 8;
  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [0:DATA_W-1] BYTES_V = DATA_W'(BYTES);
  localparam logic [0:DATA_W-1] DEPTH_V = DATA_W'(DEPTH);
  localparam logic [3:0]        WAIT_LD = 4'(WAIT_STATES);
`ifdef MEM_STAGE_SUBWORD_EN
  localparam int                OFF_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [0:DATA_W-1] addr_q, addr_d;
  logic [0:DATA_W-1] wdata_q, wdata_d;
  logic              zero_q, zero_d;
  logic              branch_q, branch_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
`ifdef MEM_STAGE_SUBWORD_EN
  logic [1:0]        size_q, size_d;
  logic [1:0]        op_size;
  logic [OFF_W-1:0]  off;
  logic              misalign;
  int                boff;
  int                hoff;
`else
  logic              unused_size;
`endif

  logic [0:DATA_W-1] rdata_q, rdata_d;
  logic              pc_src_q, pc_src_d;
  logic              err_q, err_d;

  logic              do_access;
  logic              sel_in;
  logic [0:DATA_W-1] op_addr;
  logic [0:DATA_W-1] op_wdata;
  logic              op_zero;
  logic              op_branch;
  logic              op_wr;
  logic              op_rd;

  logic [0:DATA_W-1] word_lin;
  logic [IDX_W-1:0]  idx;
  logic [0:DATA_W-1] mem_word;
  logic [0:DATA_W-1] st_word;
  logic [0:DATA_W-1] acc_rd;
  logic              acc_err;
  logic              mem_we;

  logic [0:DATA_W-1] mem_q [DEPTH];

  // With no wait states the access happens on the accept edge, so operands come straight from the bus.
  assign sel_in    = (state_q == S_IDLE);
  assign op_addr   = sel_in ? bus.alu_result : addr_q;
  assign op_wdata  = sel_in ? bus.wr_data    : wdata_q;
  assign op_zero   = sel_in ? bus.zero       : zero_q;
  assign op_branch = sel_in ? bus.branch     : branch_q;
  assign op_wr     = sel_in ? bus.mem_write  : wr_q;
  assign op_rd     = sel_in ? bus.mem_read   : rd_q;
`ifdef MEM_STAGE_SUBWORD_EN
  assign op_size   = sel_in ? bus.size       : size_q;
`else
  assign unused_size = ^bus.size;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    zero_d    = zero_q;
    branch_d  = branch_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
`ifdef MEM_STAGE_SUBWORD_EN
    size_d    = size_q;
`endif
    do_access = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          addr_d   = bus.alu_result;
          wdata_d  = bus.wr_data;
          zero_d   = bus.zero;
          branch_d = bus.branch;
          wr_d     = bus.mem_write;
          rd_d     = bus.mem_read;
`ifdef MEM_STAGE_SUBWORD_EN
          size_d   = bus.size;
`endif
          if (WAIT_STATES == 0) begin
            do_access = 1'b1;
            state_d   = S_VALID;
          end else begin
            cnt_d   = WAIT_LD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          do_access = 1'b1;
          state_d   = S_VALID;
        end
      end
      S_VALID: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    word_lin = (op_addr / BYTES_V) % DEPTH_V;
    idx      = IDX_W'(word_lin);
    mem_word = mem_q[idx];
    acc_err  = op_rd & op_wr;
    acc_rd   = '0;
    st_word  = mem_word;
`ifdef MEM_STAGE_SUBWORD_EN
    off      = OFF_W'(op_addr % BYTES_V);
    boff     = 8 * int'(off);
    hoff     = 8 * int'(off & ~OFF_W'(1));
    // A half must start on an even address and also fit inside one word.
    case (op_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = op_addr[DATA_W-1] || ((int'(off) + 2) > BYTES);
      2'b10:   misalign = (off != '0);
      default: misalign = 1'b1;
    endcase
    if (op_rd || op_wr) acc_err = acc_err | misalign;
    case (op_size)
      2'b00: begin
        acc_rd[DATA_W-8 +: 8] = mem_word[boff +: 8];
        st_word[boff +: 8]    = op_wdata[DATA_W-8 +: 8];
      end
      2'b01: begin
        acc_rd[DATA_W-16 +: 16] = mem_word[hoff +: 16];
        st_word[hoff +: 16]     = op_wdata[DATA_W-16 +: 16];
      end
      default: begin
        acc_rd  = mem_word;
        st_word = op_wdata;
      end
    endcase
`else
    acc_rd  = mem_word;
    st_word = op_wdata;
`endif
    if (acc_err || !op_rd) acc_rd = '0;
  end

  assign mem_we = do_access & op_wr & ~acc_err & ~rst_i;

  always_comb begin
    rdata_d  = rdata_q;
    pc_src_d = pc_src_q;
    err_d    = err_q;
    if (do_access) begin
      rdata_d  = acc_rd;
      pc_src_d = op_zero & op_branch;
      err_d    = acc_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      zero_q   <= 1'b0;
      branch_q <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
`ifdef MEM_STAGE_SUBWORD_EN
      size_q   <= '0;
`endif
      rdata_q  <= '0;
      pc_src_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      zero_q   <= zero_d;
      branch_q <= branch_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
`ifdef MEM_STAGE_SUBWORD_EN
      size_q   <= size_d;
`endif
      rdata_q  <= rdata_d;
      pc_src_q <= pc_src_d;
      err_q    <= err_d;
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[idx] <= st_word;
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_VALID);
  assign bus.read_data = rdata_q;
  assign bus.pc_src    = pc_src_q;
  assign bus.err       = err_q;

endmodule
